// File: rtl/audio_pkg.sv
// Shared constants and helpers for the tone synthesiser.
package audio_pkg;

  localparam int unsigned CLK_HZ    = 100_000_000;
  localparam int unsigned SILENT_HZ = 20000;   // same value as the lookup's rest code
  localparam int unsigned MIN_HZ    = 20;
  localparam int          SAMPLE_W  = 16;

  // Volume step sits just below the sign bit, so volume 7 gives 0x7000.
  function automatic logic [SAMPLE_W-1:0] amp_from_volume(input logic [2:0] vol);
    return {1'b0, vol, 12'h000};
  endfunction

endpackage

// File: rtl/seq_div32.sv
// Restoring divider: one quotient bit per clock, 32 iterations.
// The quotient register doubles as the dividend shift register.
module seq_div32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [32:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  logic [32:0] rem;
  logic [5:0]  iter;
  logic [33:0] shifted;
  logic        fits;
  logic [32:0] rem_next;

  // Trial subtraction for the current bit.
  always_comb begin
    shifted  = {rem, quotient[31]};
    fits     = (shifted >= {1'b0, divisor});
    rem_next = fits ? 33'(shifted - {1'b0, divisor}) : shifted[32:0];
  end

  // Iteration register; iter counts down to the terminal count of 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rem      <= '0;
      quotient <= '0;
      iter     <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy     <= 1'b1;
          rem      <= '0;
          quotient <= dividend;
          iter     <= 6'd32;
        end
      end else begin
        rem      <= rem_next;
        quotient <= {quotient[30:0], fits};
        iter     <= iter - 6'd1;
        if (iter == 6'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator: tone (Hz) -> half-period via sequential divide,
// glitch-free note changes on half-period boundaries, muting for rests.
module tone_synth #(
  parameter int unsigned CLK_HZ    = audio_pkg::CLK_HZ,
  parameter int unsigned SILENT_HZ = audio_pkg::SILENT_HZ,
  parameter int unsigned MIN_HZ    = audio_pkg::MIN_HZ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tone,
  input  logic [2:0]  volume,
  output logic        audio_pwm,
  output logic [15:0] sample,
  output logic        muted,
  output logic        busy
);
  import audio_pkg::*;

  logic [31:0] cur_tone;
  logic [31:0] cnt;
  logic [31:0] half_period;
  logic [31:0] pending_period;
  logic        phase;
  logic        rest;
  logic        pending;

  logic        tone_is_rest;
  logic        capture;
  logic        div_start;
  logic        div_done;
  logic        toggle;
  logic        mute_next;
  logic [31:0] quotient;
  logic [SAMPLE_W-1:0] amp;

  // Capture/toggle decisions; a new tone is only looked at once the divider
  // and the pending slot are both empty, so the latest tone wins after apply.
  always_comb begin
    tone_is_rest = (tone >= 32'(SILENT_HZ)) || (tone < 32'(MIN_HZ));
    capture      = !busy && !div_done && !pending && (tone != cur_tone);
    div_start    = capture && !tone_is_rest;
    toggle       = !rest && (cnt >= half_period - 32'd1);
    mute_next    = rest || (volume == 3'd0);
    amp          = amp_from_volume(volume);
  end

  seq_div32 u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (32'(CLK_HZ)),
    .divisor  ({tone, 1'b0}),
    .busy     (busy),
    .done     (div_done),
    .quotient (quotient)
  );

  // Tone capture, pending period, and the half-period counter. A pending
  // period waits for the next toggle unless we are coming out of a rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_tone       <= 32'(SILENT_HZ);
      rest           <= 1'b1;
      cnt            <= '0;
      phase          <= 1'b0;
      half_period    <= '0;
      pending        <= 1'b0;
      pending_period <= '0;
    end else begin
      if (capture)
        cur_tone <= tone;
      if (div_done) begin
        pending        <= 1'b1;
        pending_period <= quotient;
      end
      if (capture && tone_is_rest) begin
        rest  <= 1'b1;
        cnt   <= '0;
        phase <= 1'b0;
      end else if (pending && rest) begin
        half_period <= pending_period;
        cnt         <= '0;
        phase       <= 1'b1;
        rest        <= 1'b0;
        pending     <= 1'b0;
      end else if (toggle) begin
        cnt   <= '0;
        phase <= ~phase;
        if (pending) begin
          half_period <= pending_period;
          pending     <= 1'b0;
        end
      end else if (!rest) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // Registered outputs, one cycle behind phase/volume/rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      muted     <= 1'b1;
      audio_pwm <= 1'b0;
      sample    <= '0;
    end else begin
      muted     <= mute_next;
      audio_pwm <= !mute_next && phase;
      if (mute_next)
        sample <= '0;
      else
        sample <= phase ? amp : -amp;
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// Directed and randomized bench for tone_synth. A reduced clock frequency
// keeps half-periods short enough to measure whole waveforms.
module tb_tone_synth;

  localparam int unsigned BCLK = 500_000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tone;
  logic [2:0]  volume;
  logic        audio_pwm;
  logic [15:0] sample;
  logic        muted;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  tone_synth #(.CLK_HZ(BCLK)) dut (
    .clk       (clk),
    .rst       (rst),
    .tone      (tone),
    .volume    (volume),
    .audio_pwm (audio_pwm),
    .sample    (sample),
    .muted     (muted),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic longint ref_half(input int unsigned t);
    return longint'(BCLK / (2 * t));
  endfunction

  function automatic longint ref_sample(input bit high, input int vol);
    if (vol == 0) return 0;
    return high ? vol * 4096 : 65536 - vol * 4096;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles until audio_pwm changes; -1 if the budget runs out.
  task automatic wait_edge(input int budget, output int cyc);
    logic s;
    s = audio_pwm;
    cyc = 0;
    while (audio_pwm === s && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (audio_pwm === s) cyc = -1;
  endtask

  // Called right after a tone change that must start a division.
  task automatic settle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, 32);
  endtask

  initial begin
    int c, n, starts;
    logic pb;
    int unsigned t, prev_t;
    int vol;
    bit is_rest;

    rst = 1'b1; tone = 20000; volume = 3'd7;
    step(3);
    chk("rst_muted", muted, 1);
    chk("rst_pwm", audio_pwm, 0);
    chk("rst_sample", sample, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step(1);
    chk("idle_muted", muted, 1);

    // 440 Hz from rest
    tone = 440;
    settle("busy_len_440");
    n = 0;
    while (audio_pwm !== 1'b1 && n < 10) begin step(1); n++; end
    chk("apply_latency", n, 3);
    chk("unmuted_440", muted, 0);
    chk("sample_hi_440", sample, 16'h7000);
    wait_edge(30000, c);
    chk("half_hi_440", c, ref_half(440));
    chk("sample_lo_440", sample, 16'h9000);
    wait_edge(30000, c);
    chk("half_lo_440", c, ref_half(440));

    // 262 Hz while playing, then rest
    tone = 262;
    settle("busy_len_262");
    step(2);
    wait_edge(30000, c);
    wait_edge(30000, c);
    chk("half_262", c, ref_half(262));
    tone = 20000;
    step(1);
    chk("rest_lat1_muted", muted, 0);
    step(1);
    chk("rest_muted", muted, 1);
    chk("rest_sample", sample, 0);
    chk("rest_pwm", audio_pwm, 0);
    n = 0;
    repeat (40) begin step(1); if (busy !== 1'b0) n++; end
    chk("rest_no_div", n, 0);

    // 440 then 880 mid half-period
    tone = 440;
    settle("busy_len_440b");
    wait_edge(30000, c);
    chk("first_phase_hi", audio_pwm, 1);
    step(100);
    tone = 880;
    wait_edge(30000, c);
    chk("old_half_kept", 100 + c, ref_half(440));
    for (int i = 0; i < 3; i++) begin
      wait_edge(30000, c);
      chk("half_880", c, ref_half(880));
    end

    // 523 then back to 440 while busy: two divisions total
    tone = 523;
    starts = 0; pb = busy;
    for (int i = 0; i < 2005; i++) begin
      if (i == 5) tone = 440;
      step(1);
      if (busy === 1'b1 && pb === 1'b0) starts++;
      pb = busy;
    end
    chk("busy_starts", starts, 2);
    wait_edge(30000, c);
    wait_edge(30000, c);
    chk("settled_440_a", c, ref_half(440));
    wait_edge(30000, c);
    chk("settled_440_b", c, ref_half(440));

    // volume 0 then 3 with phase continuity
    wait_edge(30000, c);
    if (audio_pwm !== 1'b1) wait_edge(30000, c);
    step(100);
    volume = 3'd0;
    step(1);
    chk("vol0_muted", muted, 1);
    chk("vol0_pwm", audio_pwm, 0);
    chk("vol0_sample", sample, 0);
    step(99);
    volume = 3'd3;
    step(1);
    chk("vol3_pwm", audio_pwm, 1);
    chk("vol3_sample_hi", sample, 16'h3000);
    wait_edge(30000, c);
    chk("vol_continuity", c, ref_half(440) - 201);
    chk("vol3_sample_lo", sample, 16'hD000);

    // rest codes below range
    tone = 0;
    step(2);
    chk("tone0_muted", muted, 1);
    tone = 19;
    n = 0;
    repeat (40) begin step(1); if (busy !== 1'b0) n++; end
    chk("tone19_no_div", n, 0);
    chk("tone19_muted", muted, 1);

    // range edges
    tone = 19999;
    settle("busy_len_19999");
    wait_edge(1000, c);
    wait_edge(1000, c);
    chk("half_19999", c, ref_half(19999));
    tone = 20;
    settle("busy_len_20");
    step(2);
    wait_edge(30000, c);
    wait_edge(30000, c);
    chk("half_20", c, ref_half(20));

    // reset in the middle of a division
    tone = 20000;
    step(3);
    tone = 1000;
    step(10);
    chk("mid_div_busy", busy, 1);
    rst = 1'b1; tone = 20000;
    step(1);
    chk("abort_busy", busy, 0);
    chk("abort_muted", muted, 1);
    chk("abort_pwm", audio_pwm, 0);
    chk("abort_sample", sample, 0);
    rst = 1'b0;
    n = 0;
    repeat (60) begin step(1); if (busy !== 1'b0 || muted !== 1'b1) n++; end
    chk("abort_no_apply", n, 0);

    // randomized notes, rests and volumes
    prev_t = 20000;
    for (int i = 0; i < 8; i++) begin
      is_rest = ($urandom_range(0, 3) == 0);
      if (is_rest)
        t = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 19) : $urandom_range(20001, 90000);
      else
        t = $urandom_range(500, 4000);
      if (t == prev_t) t = t + 1;
      vol = $urandom_range(1, 7);
      tone = t; volume = 3'(vol);
      if (is_rest) begin
        step(2);
        chk("rnd_rest_muted", muted, 1);
        chk("rnd_rest_sample", sample, 0);
        chk("rnd_rest_busy", busy, 0);
      end else begin
        settle("rnd_busy_len");
        step(2);
        wait_edge(3000, c);
        wait_edge(3000, c);
        chk("rnd_half", c, ref_half(t));
        chk("rnd_sample", sample, ref_sample(audio_pwm, vol));
      end
      prev_t = t;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
- Downstream consumer of the beat-to-tone lookup. Converts its 32-bit tone frequency (Hz) into a square-wave audio signal.
- Drives two outputs: a 1-bit buzzer/amp line and a signed 16-bit sample for the DAC serializer.
- Derives the half-period with an internal sequential divider.
- Switches notes glitch-free, on a half-period boundary; out-of-range tones (the 20000 Hz rest code) mute.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz (divider dividend)
SILENT_HZ, 20000, tone values >= this are rests
MIN_HZ, 20, tone values < this are rests

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tone  input  32  requested frequency in Hz, from the beat-to-tone lookup; may change any cycle
volume  input  3  0 = mute, 1..7 = amplitude step
audio_pwm  output  1  square wave; 0 when muted
sample  output  16  signed sample, +amp / -amp per phase; 0 when muted
muted  output  1  current output is a rest or volume 0
busy  output  1  divider in progress

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - cnt = 0, phase = 0, half_period = 0.
  - cur_tone = SILENT_HZ, rest = 1, so muted = 1.
  - Divider idle, busy = 0, pending = 0.
  - audio_pwm = 0, sample = 0.
- rst asserted mid-division aborts the division; no result is applied.
- Capture: when the divider is idle (busy = 0, pending = 0) and tone != cur_tone, register cur_tone <= tone on that cycle (cycle T).
- Rest capture: if the captured tone >= SILENT_HZ or < MIN_HZ:
  - Set rest = 1 at T+1; no division.
  - Clear cnt and phase at T+1.
- Audible capture: clear rest only when the new period is applied (see Apply). Start the divider at T+1 with dividend CLK_HZ and divisor 2*tone (33 bits).
- Divider:
  - Restoring, 1 quotient bit per cycle, 32 iterations.
  - busy is high T+1..T+32; done pulses at T+33.
  - The quotient is latched as pending_period with pending = 1 at T+34.
  - Quotient is the floor; remainder is discarded.
- Tone changes while busy or pending are ignored. After apply, the compare runs again, so the latest tone is always eventually taken.
- Apply pending_period:
  - If rest = 1: apply immediately (next cycle). Set half_period, cnt = 0, phase = 1, rest = 0.
  - Otherwise: apply at the next toggle event. The current half-period completes with the old value; no truncated or stretched pulse.
  - Clear pending on apply.
- Counter, when not rest:
  - If cnt >= half_period - 1: cnt <= 0 and phase toggles (this is the toggle event).
  - Else cnt <= cnt + 1.
  - Compare is >=, so it stays safe if half_period shrinks.
- Amplitude: amp = {1'b0, volume, 12'h000}, so volume 7 gives 0x7000.
  - sample = phase ? amp : -amp (two's complement).
  - Registered; 1 cycle after phase/volume change.
- muted = rest | (volume == 0).
  - When muted: sample = 0 and audio_pwm = 0.
  - Otherwise audio_pwm = phase.
- volume changes take effect the next cycle, with no period disturbance.
- Tone equal to cur_tone never restarts the divider and never resets phase; steady notes continue seamlessly across beats.
- Boundaries:
  - tone = MIN_HZ gives the largest half-period, 2_500_000, which fits 32 bits.
  - tone = SILENT_HZ - 1 is audible.
  - tone = 0 is a rest, so there is no divide-by-zero.

Decomposition:
- Shared audio_pkg:
  - CLK_HZ.
  - SILENT_HZ (equals the lookup's NM0 rest code).
  - MIN_HZ.
  - Sample width 16.
  - The amplitude-from-volume function.
- Sub-module seq_div32: start/busy/done handshake; 32-bit dividend, 33-bit divisor, 32-bit quotient. One division at a time; start while busy is ignored.

Test Plan:
- Reset, then tone = 440, volume = 7:
  - busy high 32 cycles.
  - Applied half_period = 113636.
  - audio_pwm period 227272 cycles.
  - sample alternates 0x7000 / 0x9000.
- tone = 262: half_period = 190839. Then tone = 20000: muted = 1 and sample = 0 within 2 cycles; cnt and phase cleared.
- Playing 440, switch to 880 mid half-period:
  - Old half-period finishes at the full 113636 cycles.
  - Next half-periods are 56818.
  - No pulse shorter than 56818.
- Tone toggles 440→523→440 while busy:
  - Only the first change divides until apply.
  - Final settled half_period = 113636 (440).
- volume = 0 while playing 440: audio_pwm = 0, muted = 1. Restoring volume = 3 gives amp 0x3000, with phase continuity preserved.
- Edge cases:
  - tone = 0 and tone = 19: muted, busy never asserts.
  - tone = 19999: half_period = 2500.
  - rst asserted at busy cycle 10: all outputs at reset values next cycle, no later apply.
